mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between a core's instruction-fetch port and
// its load/store port. Only one transaction can be outstanding at a time.
// When both ports request together, the port that did not finish the
// previous transaction is served. A response that never arrives is
// force-completed after TIMEOUT_CYCLES response cycles with a poison word.
//
// Parameters
//   TIMEOUT_CYCLES  response cycles without mem_rvalid_i before forced
//                   completion (2..255)
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   instr_req_i/addr_i      fetch request and address
//   instr_gnt_o             fetch accepted (follows mem_gnt_i)
//   instr_rvalid_o/rdata_o  fetch response pulse and data
//   data_req_i/we_i/be_i/addr_i/wdata_i   load/store request and fields
//   data_gnt_o              load/store accepted (follows mem_gnt_i)
//   data_rvalid_o/rdata_o   load/store response pulse and data
//   mem_req_o/we_o/be_o/addr_o/wdata_o    request to memory
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory handshake and read data
//   timeout_o               pulse on forced completion
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction fetch port
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  // load/store port
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  // shared memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        timeout_o
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW  = 8;

  localparam logic [CW-1:0]  CNT_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0]  POISON_DATA  = 32'hDEADBEEF;
  localparam logic [BEW-1:0] INSTR_BE     = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  owner_e         last_owner_q, last_owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           owner_req;
  logic           in_addr;
  logic           in_resp;
  logic           resp_ok;
  logic           resp_to;
  logic           resp_done;
  logic           granted;
  logic           live;
  logic [DW-1:0]  resp_data;

  // Request line of whichever port currently owns the memory.
  assign owner_req = (owner_q == OWN_DATA) ? data_req_i : instr_req_i;

  assign in_addr   = (state_q == ST_ADDR);
  assign in_resp   = (state_q == ST_RESP);
  assign granted   = in_addr && owner_req && mem_gnt_i;

  // A real response on the last allowed cycle wins over the timeout.
  assign resp_ok   = in_resp && mem_rvalid_i;
  assign resp_to   = in_resp && !mem_rvalid_i && (cnt_q == CNT_LAST);
  assign resp_done = resp_ok || resp_to;
  assign resp_data = resp_to ? POISON_DATA : mem_rdata_i;

  // Outputs are blanked while reset is asserted so an in-flight transaction
  // can never be granted or answered during the reset cycle.
  assign live = rst_ni;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_req_i || data_req_i) begin
          state_d = ST_ADDR;
          if (instr_req_i && data_req_i) begin
            owner_d = (last_owner_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
          end else begin
            owner_d = data_req_i ? OWN_DATA : OWN_INSTR;
          end
        end
      end
      ST_ADDR: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_done) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INSTR;
      last_owner_q <= OWN_DATA;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Memory request fields come from the owner only during the address phase.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (live && in_addr) begin
      mem_req_o = owner_req;
      if (owner_q == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_we_o    = 1'b0;
        mem_be_o    = INSTR_BE;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
      end
    end
  end

  // Grant and response steering back to the owning port.
  always_comb begin
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    timeout_o      = 1'b0;
    if (live) begin
      if (owner_q == OWN_DATA) begin
        data_gnt_o    = granted;
        data_rvalid_o = resp_done;
        data_rdata_o  = resp_done ? resp_data : '0;
      end else begin
        instr_gnt_o    = granted;
        instr_rvalid_o = resp_done;
        instr_rdata_o  = resp_done ? resp_data : '0;
      end
      timeout_o = resp_to;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by random traffic. Every cycle all DUT outputs
// are compared with a transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        timeout_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .timeout_o      (timeout_o)
  );

  // Reference model: where the current transaction is (0 none, 1 waiting
  // for grant, 2 waiting for data), who owns it, who finished last, and
  // which response cycle (1-based) we are on.
  int m_phase    = 0;
  bit m_own_data = 1'b0;
  bit m_last_dat = 1'b1;
  int m_resp_n   = 0;

  bit          e_mreq, e_mwe, e_ig, e_dg, e_iv, e_dv, e_to;
  logic [3:0]  e_mbe;
  logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;

  function automatic void model_outputs();
    bit          r;
    bit          fin;
    bit          tmo;
    logic [31:0] d;
    e_mreq = 0; e_mwe = 0; e_mbe = '0; e_maddr = '0; e_mwdata = '0;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_to = 0; e_ird = '0; e_drd = '0;
    if (rst_ni) begin
      if (m_phase == 1) begin
        r      = m_own_data ? data_req_i : instr_req_i;
        e_mreq = r;
        if (m_own_data) begin
          e_mwe = data_we_i; e_mbe = data_be_i;
          e_maddr = data_addr_i; e_mwdata = data_wdata_i;
          e_dg = r && mem_gnt_i;
        end else begin
          e_mwe = 0; e_mbe = 4'hF; e_maddr = instr_addr_i; e_mwdata = '0;
          e_ig = r && mem_gnt_i;
        end
      end else if (m_phase == 2) begin
        tmo = !mem_rvalid_i && (m_resp_n == TO);
        fin = mem_rvalid_i || tmo;
        d   = tmo ? 32'hDEADBEEF : mem_rdata_i;
        if (fin) begin
          if (m_own_data) begin e_dv = 1; e_drd = d; end
          else begin e_iv = 1; e_ird = d; end
          e_to = tmo;
        end
      end
    end
  endfunction

  function automatic void model_clock();
    bit r;
    if (!rst_ni) begin
      m_phase = 0; m_own_data = 0; m_last_dat = 1; m_resp_n = 0;
      return;
    end
    case (m_phase)
      0: if (instr_req_i || data_req_i) begin
           m_phase    = 1;
           m_own_data = (instr_req_i && data_req_i) ? !m_last_dat : data_req_i;
         end
      1: begin
           r = m_own_data ? data_req_i : instr_req_i;
           if (!r) m_phase = 0;
           else if (mem_gnt_i) begin m_phase = 2; m_resp_n = 1; end
         end
      2: if (mem_rvalid_i || m_resp_n == TO) begin
           m_phase = 0; m_last_dat = m_own_data;
         end else begin
           m_resp_n++;
         end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic settle_check();
    #1;
    model_outputs();
    chk("mem_req",      32'(mem_req_o),      32'(e_mreq));
    chk("mem_we",       32'(mem_we_o),       32'(e_mwe));
    chk("mem_be",       32'(mem_be_o),       32'(e_mbe));
    chk("mem_addr",     mem_addr_o,          e_maddr);
    chk("mem_wdata",    mem_wdata_o,         e_mwdata);
    chk("instr_gnt",    32'(instr_gnt_o),    32'(e_ig));
    chk("data_gnt",     32'(data_gnt_o),     32'(e_dg));
    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(e_iv));
    chk("data_rvalid",  32'(data_rvalid_o),  32'(e_dv));
    chk("instr_rdata",  instr_rdata_o,       e_ird);
    chk("data_rdata",   data_rdata_o,        e_drd);
    chk("timeout",      32'(timeout_o),      32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic cyc();
    settle_check();
    tick();
  endtask

  task automatic quiet();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  int gq[$];

  initial begin
    // Reset state
    rst_ni = 0;
    quiet();
    cyc();
    settle_check();
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    tick();
    rst_ni = 1;

    // Single instruction fetch at minimum latency
    instr_req_i = 1; instr_addr_i = 32'h0000000A; mem_gnt_i = 1;
    cyc();
    settle_check();
    chk("fetch_mem_req",  32'(mem_req_o),   32'd1);
    chk("fetch_addr",     mem_addr_o,       32'h0000000A);
    chk("fetch_be",       32'(mem_be_o),    32'hF);
    chk("fetch_gnt",      32'(instr_gnt_o), 32'd1);
    tick();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h002180B3;
    settle_check();
    chk("fetch_rvalid",   32'(instr_rvalid_o), 32'd1);
    chk("fetch_rdata",    instr_rdata_o,       32'h002180B3);
    tick();
    quiet();
    cyc();

    // Round-robin with both ports requesting continuously from reset
    rst_ni = 0;
    cyc();
    rst_ni = 1;
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    instr_addr_i = 32'h0000_1000; data_addr_i = 32'h0000_2000; mem_rdata_i = 32'h0BAD_F00D;
    for (int i = 0; i < 12; i++) begin
      settle_check();
      if (instr_gnt_o) gq.push_back(0);
      if (data_gnt_o)  gq.push_back(1);
      tick();
    end
    chk("rr_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 2));
    quiet();
    cyc();

    // Store stalled by memory for three cycles
    data_req_i = 1; data_we_i = 1; data_be_i = 4'h3;
    data_addr_i = 32'h0000_0100; data_wdata_i = 32'h12345678;
    cyc();
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("stall_req",   32'(mem_req_o),   32'd1);
      chk("stall_we",    32'(mem_we_o),    32'd1);
      chk("stall_be",    32'(mem_be_o),    32'h3);
      chk("stall_wdata", mem_wdata_o,      32'h12345678);
      chk("stall_gnt",   32'(data_gnt_o),  32'd0);
      tick();
    end
    mem_gnt_i = 1;
    settle_check();
    chk("stall_gnt_now", 32'(data_gnt_o), 32'd1);
    tick();
    data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_55AA;
    settle_check();
    chk("store_rvalid", 32'(data_rvalid_o), 32'd1);
    tick();
    quiet();
    cyc();

    // Response timeout followed by a stray late response
    data_req_i = 1; data_addr_i = 32'h0000_0200; mem_gnt_i = 1;
    cyc();
    cyc();
    data_req_i = 0; mem_gnt_i = 0;
    for (int k = 1; k <= TO; k++) begin
      settle_check();
      chk("to_rvalid", 32'(data_rvalid_o), 32'(k == TO));
      chk("to_pulse",  32'(timeout_o),     32'(k == TO));
      if (k == TO) chk("to_poison", data_rdata_o, 32'hDEADBEEF);
      tick();
    end
    mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
    settle_check();
    chk("stray_drvalid", 32'(data_rvalid_o),  32'd0);
    chk("stray_irvalid", 32'(instr_rvalid_o), 32'd0);
    tick();
    quiet();
    cyc();

    // Reset during a response: finish a fetch so data would win the next tie
    instr_req_i = 1; mem_gnt_i = 1;
    cyc();
    cyc();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    cyc();
    quiet();
    data_req_i = 1; mem_gnt_i = 1;
    cyc();
    cyc();
    data_req_i = 0; mem_gnt_i = 0;
    cyc();
    rst_ni = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001;
    settle_check();
    chk("rst_mid_drvalid", 32'(data_rvalid_o), 32'd0);
    chk("rst_mid_timeout", 32'(timeout_o),     32'd0);
    tick();
    rst_ni = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
    settle_check();
    chk("post_rst_drvalid", 32'(data_rvalid_o), 32'd0);
    tick();
    mem_rvalid_i = 0;
    settle_check();
    chk("post_rst_igrant", 32'(instr_gnt_o), 32'd1);
    chk("post_rst_dgrant", 32'(data_gnt_o),  32'd0);
    tick();
    quiet();
    mem_rvalid_i = 1;
    cyc();
    quiet();
    cyc();

    // Random traffic including occasional resets
    for (int n = 0; n < 1500; n++) begin
      rst_ni       = ($urandom_range(63) != 0);
      instr_req_i  = ($urandom_range(9) < 6);
      instr_addr_i = $urandom;
      data_req_i   = ($urandom_range(9) < 6);
      data_we_i    = 1'($urandom);
      data_be_i    = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
      mem_gnt_i    = ($urandom_range(2) != 0);
      mem_rvalid_i = ($urandom_range(3) == 0);
      mem_rdata_i  = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
